// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op/state encodings and widths for the shared barrel shifter
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational 5-stage mux barrel shifter (SLL/SRL/SRA, ROR under SHIFT_ARB_ROTATE_EN)
module shift_core
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_stage [0:AMT_W];

    assign w_stage[0] = i_a;

    // Stage k shifts by 2**k when amt bit k is set; SRA fill uses the original sign bit.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [DATA_W-1:0] w_shifted;

        always_comb begin
            w_shifted = w_stage[k];
            case (i_op)
                OP_SLL:  w_shifted = {w_stage[k][DATA_W-1-SH:0], {SH{1'b0}}};
                OP_SRL:  w_shifted = {{SH{1'b0}}, w_stage[k][DATA_W-1:SH]};
                OP_SRA:  w_shifted = {{SH{i_a[DATA_W-1]}}, w_stage[k][DATA_W-1:SH]};
                default: begin
`ifdef SHIFT_ARB_ROTATE_EN
                    w_shifted = {w_stage[k][SH-1:0], w_stage[k][DATA_W-1:SH]};
`else
                    w_shifted = w_stage[k];
`endif
                end
            endcase
        end

        assign w_stage[k+1] = i_amt[k] ? w_shifted : w_stage[k];
    end

    assign o_result = w_stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin shared shifter with one-entry result buffer (ROR via SHIFT_ARB_ROTATE_EN)
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [AMT_W*NUM_REQ-1:0]  req_amt,
    input  logic [2*NUM_REQ-1:0]      req_op,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy
);

    localparam int NSLOT = 1 << IDW;

    state_t             r_state;
    logic [IDW-1:0]     r_owner;
    logic [IDW-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]  r_result;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic               r_busy;

    logic [NSLOT-1:0]   w_valid_pad;
    logic [NSLOT-1:0]   w_resp_ready_pad;
    logic [IDW-1:0]     w_cand;
    logic [IDW-1:0]     w_gnt_idx;
    logic               w_gnt_found;
    logic               w_can_accept;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [DATA_W-1:0]  w_sel_a;
    logic [AMT_W-1:0]   w_sel_amt;
    logic [1:0]         w_sel_op;
    logic [DATA_W-1:0]  w_shift_out;

    // Padding to 2**IDW lets the IDW-bit owner/candidate index the vectors directly.
    always_comb begin
        w_valid_pad                   = '0;
        w_valid_pad[NUM_REQ-1:0]      = req_valid;
        w_resp_ready_pad              = '0;
        w_resp_ready_pad[NUM_REQ-1:0] = resp_ready;
    end

    // Walk candidates farthest-first so the nearest one after rr_ptr wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (w_valid_pad[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    assign w_can_accept = reset & ((r_state == ST_IDLE) |
                                   ((r_state == ST_HOLD) & w_resp_ready_pad[r_owner]));
    assign w_xfer       = w_can_accept & w_gnt_found;
    assign w_gnt_onehot = NUM_REQ'(1) << w_gnt_idx;
    assign req_ready    = w_xfer ? w_gnt_onehot : '0;

    always_comb begin
        w_sel_a   = '0;
        w_sel_amt = '0;
        w_sel_op  = OP_SLL;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_a   = req_data[DATA_W*i +: DATA_W];
                w_sel_amt = req_amt[AMT_W*i +: AMT_W];
                w_sel_op  = req_op[2*i +: 2];
            end
        end
    end

    shift_core u_core (
        .i_a      (w_sel_a),
        .i_amt    (w_sel_amt),
        .i_op     (w_sel_op),
        .o_result (w_shift_out)
    );

    // A refill takes precedence over a drain, so a draining HOLD slot is reused in the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= IDW'(NUM_REQ - 1);
            r_result     <= '0;
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
        end else if (w_xfer) begin
            r_state      <= ST_HOLD;
            r_owner      <= w_gnt_idx;
            r_rr_ptr     <= w_gnt_idx;
            r_result     <= w_shift_out;
            r_resp_valid <= w_gnt_onehot;
            r_busy       <= 1'b1;
        end else if ((r_state == ST_HOLD) && w_resp_ready_pad[r_owner]) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_result;
    assign busy       = r_busy;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel shifter (SLL/SRL/SRA) between NUM_REQ requesters, e.g. the ALU path and the multdiv unit.
- Uses a round-robin valid/ready arbiter, a single-entry registered result buffer, and a two-state FSM.
- Results are routed back to the requester that was granted.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the grant-index field; covers NUM_REQ=4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  32*NUM_REQ  operand A, packed; requester i is at [32*i+31:32*i].
- req_amt  in  5*NUM_REQ  shift amount, packed.
- req_op  in  2*NUM_REQ  op code, packed: 00 SLL, 01 SRL, 10 SRA, 11 ROR (optional feature).
- resp_valid  out  NUM_REQ  result valid, one-hot or zero.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  32  shifted result; meaningful only while a resp_valid bit is high.
- busy  out  1  result buffer occupied.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=NUM_REQ-1 so requester 0 has top priority after reset, resp_valid=0, resp_data=0, busy=0. req_ready is combinational and therefore 0 during reset.
- FSM states: IDLE (buffer empty), HOLD (buffer full).
- can_accept = (state==IDLE) | (state==HOLD & resp_ready[owner]); a simultaneous drain and refill is allowed, giving full throughput.
- Grant selection, combinational:
  - Candidate order is rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - The first requester with req_valid high wins.
  - req_ready[g]=can_accept & req_valid[g]; all other bits are 0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] on a clock edge. On transfer:
  - Shifter output on the granted operands goes into the result register.
  - owner<=g; rr_ptr<=g; state<=HOLD.
- Latency: the result is visible the cycle after acceptance. resp_valid[owner]=1 while in HOLD.
- Drain: resp_ready[owner]=1 in HOLD with no new transfer -> state<=IDLE, resp_valid<=0. resp_ready on non-owner bits is ignored.
- Result is held stable while in HOLD until drained; requesters must not drop req_valid before ready.
- Arithmetic:
  - amt taken modulo 32 (5-bit field).
  - SRA replicates bit 31.
  - SRL and SLL zero-fill.
  - amt=0 returns A unchanged for every op.
- No requests: grant none, state unchanged, rr_ptr unchanged.
- All requesters valid: strict rotation 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: a buffered result is discarded, resp_valid drops immediately, and rr_ptr is reinitialised.

Optional Feature:
- Macro SHIFT_ARB_ROTATE_EN.
- Defined: op 11 is rotate-right by amt; bits shifted out of bit 0 re-enter at bit 31.
- Undefined: op 11 returns A unchanged (pass-through) and is still arbitrated and responded to normally.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
  - state encodings ST_IDLE, ST_HOLD;
  - constants DATA_W=32, AMT_W=5.
- One natural sub-module: shift_core.
  - Purely combinational 5-stage mux shifter taking A, amt, op, returning result.
  - Contains the ROR path under SHIFT_ARB_ROTATE_EN.
- The arbiter, FSM and result register live in shift_arbiter.

Test Plan:
- Reset then a single request: req0 A=32'h8000_0010, amt=4, op=SRA -> req_ready[0] that cycle; next cycle resp_valid=2'b01, resp_data=32'hF800_0001.
- Both valid every cycle, resp_ready=all ones: req0 SLL A=1 amt=31; req1 SRL A=32'h8000_0000 amt=31.
  - Grants alternate 0,1,0,1 starting with 0, one per cycle.
  - Results are 32'h8000_0000 and 32'h0000_0001 respectively.
- Backpressure: req1 accepted, resp_ready[1]=0 for 3 cycles while req0 valid.
  - req_ready[0]=0 throughout; resp_data stable.
  - resp_ready[1]=1 -> same cycle req_ready[0]=1, then resp_valid=2'b01 next cycle.
- amt=0 on each op with A=32'hDEAD_BEEF -> resp_data=32'hDEAD_BEEF; SRA amt=31 on A=32'h7FFF_FFFF -> 0, on 32'h8000_0000 -> 32'hFFFF_FFFF.
- op=11, A=32'h0000_00F1, amt=4:
  - Macro defined -> 32'h1000_000F.
  - Macro undefined -> 32'h0000_00F1.
- Assert reset in HOLD with resp_valid=2'b10 -> resp_valid=0 and busy=0 immediately; after release, req0 and req1 both valid -> req0 granted first.
